// File: rtl/result_accum_pkg.sv
// result_accum_pkg: shared types, constants and width helper for the result_accum block.
package result_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } state_e;

  localparam int ID_W = 4;

  function automatic int sum_width(input int dw, input int len);
    return dw + $clog2(len);
  endfunction

endpackage

// File: rtl/result_accum_if.sv
// result_accum_if: sample-input and frame-record-output handshakes of result_accum.
// out_min/out_max exist only when RESULT_ACCUM_MINMAX_EN is defined.
interface result_accum_if #(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 4
);
  localparam int SUM_W = result_accum_pkg::sum_width(DW, FRAME_LEN);

  logic                              in_valid;
  logic                              in_ready;
  logic [DW-1:0]                     in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [SUM_W-1:0]                  out_sum;
  logic [result_accum_pkg::ID_W-1:0] out_id;

`ifdef RESULT_ACCUM_MINMAX_EN
  logic [DW-1:0]                     out_min;
  logic [DW-1:0]                     out_max;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_id, out_min, out_max
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_id, out_min, out_max
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_id
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_id
  );
`endif

endinterface

// File: rtl/result_accum_minmax.sv
// result_minmax: running per-frame minimum/maximum of accepted samples.
// Outputs are the running values folded with the sample currently presented.
module result_minmax #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_frame_start,
  input  logic          i_upd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_min_nxt,
  output logic [DW-1:0] o_max_nxt
);
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;

  assign o_min_nxt = (i_data < r_min) ? i_data : r_min;
  assign o_max_nxt = (i_data > r_max) ? i_data : r_max;

  // Running extremes restart at all-ones / zero on clear or when a frame closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_clear || i_frame_start) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_upd) begin
      r_min <= o_min_nxt;
      r_max <= o_max_nxt;
    end
  end

endmodule

// File: rtl/result_accum.sv
// result_accum: sums FRAME_LEN samples per frame and presents a registered frame record.
// Per-frame min/max outputs are built only when RESULT_ACCUM_MINMAX_EN is defined.
module result_accum
  import result_accum_pkg::*;
#(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  result_accum_if.slave bus
);
  localparam int               SUM_W    = sum_width(DW, FRAME_LEN);
  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] w_acc_nxt;
  logic [SUM_W-1:0] w_sum;
  logic [ID_W-1:0]  r_id_next;
  logic             r_out_valid;
  logic [SUM_W-1:0] r_out_sum;
  logic [ID_W-1:0]  r_out_id;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_load;

  // Only the closing sample stalls, and only behind an unconsumed record
  assign w_in_ready = !clear && !((r_state == LAST) && r_out_valid);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sum      = r_acc + {{(SUM_W-DW){1'b0}}, bus.in_data};
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_load      = 1'b0;
    if (clear) begin
      w_state_nxt = ACCUM;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
    end else if (w_accept) begin
      case (r_state)
        ACCUM: begin
          w_acc_nxt   = w_sum;
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == LAST_CNT) ? LAST : ACCUM;
        end
        LAST: begin
          w_load      = 1'b1;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCUM;
        end
        default: begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCUM;
        end
      endcase
    end else begin
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Record register: load on the closing sample, drop on consumption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_id    <= '0;
      r_id_next   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_id    <= r_id_next;
      r_id_next   <= r_id_next + ID_W'(1);
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_id    = r_out_id;

`ifdef RESULT_ACCUM_MINMAX_EN
  logic [DW-1:0] w_min_nxt;
  logic [DW-1:0] w_max_nxt;
  logic [DW-1:0] r_out_min;
  logic [DW-1:0] r_out_max;

  result_minmax #(
    .DW(DW)
  ) u_minmax (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (clear),
    .i_frame_start(w_load),
    .i_upd        (w_accept),
    .i_data       (bus.in_data),
    .o_min_nxt    (w_min_nxt),
    .o_max_nxt    (w_max_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_min <= '0;
      r_out_max <= '0;
    end else if (w_load) begin
      r_out_min <= w_min_nxt;
      r_out_max <= w_max_nxt;
    end
  end

  assign bus.out_min = r_out_min;
  assign bus.out_max = r_out_max;
`endif

endmodule

// File: tb/tb_result_accum.sv
// tb_result_accum: directed scoreboard bench for result_accum (DW=8, FRAME_LEN=4).
// Min/max fields are compared when RESULT_ACCUM_MINMAX_EN is defined.
module tb_result_accum;
  import result_accum_pkg::*;

  localparam int DW        = 8;
  localparam int FRAME_LEN = 4;
  localparam int SUM_W     = DW + $clog2(FRAME_LEN);

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  id;
    logic [DW-1:0]    mn;
    logic [DW-1:0]    mx;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;

  result_accum_if #(.DW(DW), .FRAME_LEN(FRAME_LEN)) bus ();

  result_accum #(.DW(DW), .FRAME_LEN(FRAME_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int        compared   = 0;
  int        mismatched = 0;
  int        cyc        = 0;
  rec_t      sb_q[$];
  int        m_acc, m_cnt, m_min, m_max;
  logic [ID_W-1:0] m_id;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_frame_reset();
    m_acc = 0;
    m_cnt = 0;
    m_min = 255;
    m_max = 0;
  endtask

  // Scoreboard: each consumed record is compared against the oldest expectation
  always @(negedge clk) begin
    rec_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_sum", 32'(bus.out_sum), 32'(e.sum));
        check("out_id", 32'(bus.out_id), 32'(e.id));
`ifdef RESULT_ACCUM_MINMAX_EN
        check("out_min", 32'(bus.out_min), 32'(e.mn));
        check("out_max", 32'(bus.out_max), 32'(e.mx));
`endif
      end
    end
  end

  task automatic send(input logic [DW-1:0] v);
    int   waited;
    rec_t r;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("accept_timeout", 32'(waited < 50), 32'd1);
    if (waited < 50) begin
      @(posedge clk);
      #1;
      m_acc += int'(v);
      m_cnt++;
      if (int'(v) < m_min) m_min = int'(v);
      if (int'(v) > m_max) m_max = int'(v);
      if (m_cnt == FRAME_LEN) begin
        r.sum = SUM_W'(m_acc);
        r.id  = m_id;
        r.mn  = DW'(m_min);
        r.mx  = DW'(m_max);
        sb_q.push_back(r);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        m_id++;
        model_frame_reset();
      end
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_id          = '0;
    model_frame_reset();

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef RESULT_ACCUM_MINMAX_EN
    check("rst_out_min", 32'(bus.out_min), 32'd0);
    check("rst_out_max", 32'(bus.out_max), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic frame
    bus.out_ready = 1'b1;
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    check("basic_sum", 32'(bus.out_sum), 32'd100);
    check("basic_id", 32'(bus.out_id), 32'd0);
    drain();

    // Maximum-width frame then all-zero frame
    repeat (FRAME_LEN) send(8'd255);
    check("max_sum", 32'(bus.out_sum), 32'd1020);
    repeat (FRAME_LEN) send(8'd0);
    check("zero_sum", 32'(bus.out_sum), 32'd0);
    check("zero_id", 32'(bus.out_id), 32'd2);
    drain();

    // Backpressure: only the closing sample of the second frame stalls
    bus.out_ready = 1'b0;
    repeat (7) send(8'd1);
    bus.in_data = 8'd1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_sum", 32'(bus.out_sum), 32'd4);
      check("bp_hold_id", 32'(bus.out_id), 32'd3);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("bp_valid_fell", 32'(bus.out_valid), 32'd0);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    send(8'd1);
    check("bp_sum2", 32'(bus.out_sum), 32'd4);
    check("bp_id2", 32'(bus.out_id), 32'd4);
    bus.out_ready = 1'b1;
    drain();

    // Clear mid-frame discards partial sum and the presented sample
    send(8'd100); send(8'd50);
    bus.in_data = 8'd77;
    clear       = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    model_frame_reset();
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    check("clr_sum", 32'(bus.out_sum), 32'd10);
    drain();

    // Clear while the closing sample is presented: no record
    send(8'd9); send(8'd9); send(8'd9);
    bus.in_data = 8'd9;
    clear       = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    bus.in_valid = 1'b0;
    model_frame_reset();
    check("clr_last_no_record", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("clr_last_no_record2", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-frame with a pending record
    bus.out_ready = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    send(8'd7); send(8'd8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_sum", 32'(bus.out_sum), 32'd0);
    check("arst_out_id", 32'(bus.out_id), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef RESULT_ACCUM_MINMAX_EN
    check("arst_out_min", 32'(bus.out_min), 32'd0);
    check("arst_out_max", 32'(bus.out_max), 32'd0);
`endif
    bus.in_valid = 1'b0;
    sb_q.delete();
    model_frame_reset();
    m_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (FRAME_LEN) send(8'd5);
    check("arst_new_sum", 32'(bus.out_sum), 32'd20);
    check("arst_new_id", 32'(bus.out_id), 32'd0);
    drain();

    // Sixteen more back-to-back frames: id wraps to 0, no bubbles
    c0 = cyc;
    repeat (16 * FRAME_LEN) send(DW'($urandom_range(0, 255)));
    check("throughput_cycles", 32'(cyc - c0), 32'(16 * FRAME_LEN));
    check("wrap_id", 32'(bus.out_id), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/result_accum.md
# result_accum

Downstream consumer of the adder/subtractor stage's 8-bit result `y`. Accepts one result per cycle over a valid/ready handshake. Accumulates FRAME_LEN results into a frame sum and presents each completed frame as a registered record on a second valid/ready interface. Accumulation of the next frame overlaps with the previous frame waiting at the output.

## Interface
- `DW`, default 8: result width; matches the arithmetic stage's output width.
- `FRAME_LEN`, default 4: samples per frame; legal range is 2..256.
- `SUM_W`: localparam, not overridable; equals `DW + $clog2(FRAME_LEN)`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous abort of the partial frame.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a sample.
- `in_data` in DW: unsigned result sample.
- `out_valid` out 1: frame record is valid.
- `out_ready` in 1: downstream accepts the frame record.
- `out_sum` out SUM_W: sum of the frame's samples.
- `out_id` out 4: frame sequence number.
- `out_min` out DW: smallest sample in the frame. Present only with `RESULT_ACCUM_MINMAX_EN`.
- `out_max` out DW: largest sample in the frame. Present only with `RESULT_ACCUM_MINMAX_EN`.

## Operation
- **Sample acceptance:** a sample is accepted when `in_valid && in_ready` at a rising edge.
- **Internal state:**
  - `acc` (SUM_W bits): running sum.
  - `cnt` (0..FRAME_LEN-1): samples in the current frame.
  - `id_next` (4 bits): ID for the next frame.
  - Running min/max (when the macro is enabled).
- **State machine, two states:**
  - ACCUM: `cnt < FRAME_LEN-1`.
  - LAST: `cnt == FRAME_LEN-1`.
- **Non-final sample accepted:** `acc += in_data`, `cnt++`. In LAST, `cnt == FRAME_LEN-1` after this update.
- **Final sample accepted (in LAST):**
  - `out_sum <= acc + in_data`, `out_id <= id_next`, `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`, `id_next++`, returning to ACCUM.
- **`in_ready` rule:** `in_ready = !clear && !(state==LAST && out_valid)`.
  - Only the final sample of a frame stalls, and only while the previous record is still unconsumed.
  - There is no combinational path from `out_ready` to `in_ready`.
- **Output handshake:** `out_valid` falls on `out_valid && out_ready`. A final-sample load in that same cycle is impossible by the `in_ready` rule.
- **Record stability:** output fields are stable while `out_valid && !out_ready`.
- **Width:** the adder is SUM_W wide and cannot overflow. Samples are unsigned; wrapped subtractor results are summed as-is.
- **`clear`:**
  - Zeroes `acc`, `cnt` and the running min/max, and forces ACCUM.
  - The sample presented in that cycle is discarded (`in_ready` is 0).
  - `clear` does not touch a pending output record or `id_next`.
- **`out_id`:** wraps 15 → 0.

## Timing
- **Latency:** `out_valid` rises 1 cycle after the final sample's accept edge.
- **Throughput:** 1 sample/cycle with `out_ready` held high. Steady state yields one frame every FRAME_LEN cycles with no bubbles.
- **Reset values:**
  - `out_valid = 0`, `out_sum = 0`, `out_id = 0`.
  - `out_min = 0`, `out_max = 0`.
  - Internal `acc = 0`, `cnt = 0`, `id_next = 0`, running min = all-ones, running max = 0.
  - `in_ready` is 1 during and immediately after reset, provided `clear` is low.
- **Reset mid-frame:** the partial frame and any pending record are lost. The first frame after reset has `out_id = 0`.
- **`clear` with final sample presented:** `clear` wins and no record is produced.

## Configuration
- **`RESULT_ACCUM_MINMAX_EN` defined:**
  - Running min/max are updated on each accepted sample.
  - On the final sample, `out_min`/`out_max` load `min(run_min, in_data)` / `max(run_max, in_data)`.
  - Running values reset to all-ones / 0 at frame start.
- **Not defined:** `out_min`/`out_max` ports, registers and compare logic are absent. All other behaviour is identical.

## Structure
- **Package `result_accum_pkg`:**
  - State enum `{ACCUM, LAST}`.
  - Constant `ID_W = 4`.
  - Function `sum_width(dw, len)`, used to derive SUM_W.
- **Sub-module `result_minmax`:**
  - Ports: running min/max registers, update enable, frame-start and clear inputs.
  - Instantiated only under the macro.

## Test plan
Defaults: `DW=8`, `FRAME_LEN=4`, macro enabled.
- **Basic frame:** samples 10, 20, 30, 40 with `out_ready=1` → one cycle after the 4th accept: `out_sum=100`, `out_id=0`, `out_min=10`, `out_max=40`.
- **Max width:** 255 ×4 → `out_sum=1020` (10 bits, no overflow). Next frame 0 ×4 → `out_sum=0`, `out_id=1`.
- **Backpressure:** `out_ready=0`, 8 samples of value 1 offered back-to-back.
  - First 7 are accepted; 8th sees `in_ready=0`; record `sum=4, id=0` stays stable.
  - Raise `out_ready` for 1 cycle → 8th accepted next cycle → record `sum=4, id=1`.
- **Clear mid-frame:** after samples 100 and 50, pulse `clear` while presenting 77 (discarded). Then samples 1, 2, 3, 4 → `out_sum=10`, `out_min=1`, `out_max=4`.
- **ID wrap:** 17 consecutive frames → `out_id` runs 0..15 then 0.
- **Async reset mid-frame:** assert `rst_n=0` after 2 samples while a record is pending.
  - All outputs drop to reset values immediately, without waiting for a clock edge.
  - After release, 4 samples of value 5 → `out_sum=20`, `out_id=0`.
